// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives the data-memory req/ack bus for LW/SW,
// stalls the front of the pipeline while an access is outstanding, resolves
// the branch decision and owns the MEM/WB pipeline register.
//
// Bus handshake: dmem_req is held high from the first cycle an aligned LW/SW
// sits in MEM until the cycle dmem_ack is seen (dmem_rdata valid in that same
// cycle) or the access times out; dmem_we/addr/wdata are stable throughout
// because EX/MEM is frozen by mem_stall.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write_mem,
    input  logic        mem_to_reg_mem,
    input  logic        mem_read_mem,
    input  logic        mem_write_mem,
    input  logic        branch_mem,
    input  logic        zero_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] read_data2_mem,
    input  logic [4:0]  write_reg_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        pc_src,
    output logic        reg_write_wb,
    output logic        mem_to_reg_wb,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_result_wb,
    output logic [4:0]  write_reg_wb,
    output logic        mem_fault,
    output logic        state_dbg
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    // Value of cnt in the last cycle a request may stay unacknowledged.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;

    logic mem_op;
    logic aligned;
    logic misaligned;
    logic abort;
    logic timeout_abort;
    logic drop;
    logic read_done;

    assign mem_op        = mem_read_mem | mem_write_mem;
    assign aligned       = (alu_result_mem[1:0] == 2'b00);
    assign misaligned    = mem_op & ~aligned & (state == IDLE);
    assign abort         = (state == WAIT) && (cnt == CNT_LAST);
    // An ack arriving in the last allowed cycle still completes normally.
    assign timeout_abort = abort & ~dmem_ack;
    assign drop          = misaligned | timeout_abort;

    assign dmem_req   = ~reset & ((state == WAIT) | (mem_op & aligned));
    // Write wins when both read and write are flagged.
    assign dmem_we    = mem_write_mem;
    assign dmem_addr  = alu_result_mem;
    assign dmem_wdata = read_data2_mem;
    assign mem_stall  = dmem_req & ~dmem_ack & ~abort;
    assign read_done  = dmem_req & dmem_ack & mem_read_mem & ~mem_write_mem;

    assign pc_src     = branch_mem & zero_mem;
    assign state_dbg  = (state == WAIT);

    // State register and wait-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state: enter WAIT on an unacknowledged request, leave on ack or timeout.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (dmem_req && !dmem_ack) begin
                    state_next = WAIT;
                    cnt_next   = 8'd1;
                end
            end
            WAIT: begin
                if (dmem_ack || abort) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // MEM/WB register: bubble while stalled or when the access is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_wb  <= 1'b0;
            mem_to_reg_wb <= 1'b0;
            read_data_wb  <= 32'd0;
            alu_result_wb <= 32'd0;
            write_reg_wb  <= 5'd0;
            mem_fault     <= 1'b0;
        end else if (mem_stall || drop) begin
            reg_write_wb  <= 1'b0;
            mem_to_reg_wb <= 1'b0;
            read_data_wb  <= 32'd0;
            alu_result_wb <= 32'd0;
            write_reg_wb  <= 5'd0;
            mem_fault     <= drop;
        end else begin
            reg_write_wb  <= reg_write_mem;
            mem_to_reg_wb <= mem_to_reg_mem;
            read_data_wb  <= read_done ? dmem_rdata : 32'd0;
            alu_result_wb <= alu_result_mem;
            write_reg_wb  <= write_reg_mem;
            mem_fault     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl with TIMEOUT=4: directed instruction sequence,
// a per-cycle reference model of the memory stage, and literal spot checks.
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        reg_write_mem, mem_to_reg_mem, mem_read_mem, mem_write_mem;
    logic        branch_mem, zero_mem;
    logic [31:0] alu_result_mem, read_data2_mem;
    logic [4:0]  write_reg_mem;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_stall, pc_src;
    logic        reg_write_wb, mem_to_reg_wb, mem_fault, state_dbg;
    logic [31:0] read_data_wb, alu_result_wb;
    logic [4:0]  write_reg_wb;

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .reg_write_mem(reg_write_mem), .mem_to_reg_mem(mem_to_reg_mem),
        .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
        .branch_mem(branch_mem), .zero_mem(zero_mem),
        .alu_result_mem(alu_result_mem), .read_data2_mem(read_data2_mem),
        .write_reg_mem(write_reg_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .pc_src(pc_src),
        .reg_write_wb(reg_write_wb), .mem_to_reg_wb(mem_to_reg_wb),
        .read_data_wb(read_data_wb), .alu_result_wb(alu_result_wb),
        .write_reg_wb(write_reg_wb), .mem_fault(mem_fault), .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_req, cnt_stall, cnt_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + compare ----------------
    // age = cycles the current aligned access has already been waiting.
    int          age = 0;
    logic        e_rw = 0, e_mtr = 0, e_fault = 0;
    logic [31:0] e_rd = 0, e_alu = 0;
    logic [4:0]  e_wr = 0;

    always begin : model
        logic        m_op, m_al, x_req, x_to, x_stall;
        logic        n_rw, n_mtr, n_fault;
        logic [31:0] n_rd, n_alu;
        logic [4:0]  n_wr;
        @(negedge clk);
        m_op    = mem_read_mem | mem_write_mem;
        m_al    = (alu_result_mem[1:0] == 2'b00);
        x_req   = !reset && m_op && m_al;
        x_to    = x_req && !dmem_ack && (age == TIMEOUT - 1);
        x_stall = x_req && !dmem_ack && !x_to;
        if (reset) begin
            e_rw = 0; e_mtr = 0; e_rd = 0; e_alu = 0; e_wr = 0; e_fault = 0;
        end
        check("dmem_req", dmem_req, x_req);
        check("dmem_we", dmem_we, mem_write_mem);
        check("dmem_addr", dmem_addr, alu_result_mem);
        check("dmem_wdata", dmem_wdata, read_data2_mem);
        check("mem_stall", mem_stall, x_stall);
        check("pc_src", pc_src, branch_mem & zero_mem);
        check("reg_write_wb", reg_write_wb, e_rw);
        check("mem_to_reg_wb", mem_to_reg_wb, e_mtr);
        check("read_data_wb", read_data_wb, e_rd);
        check("alu_result_wb", alu_result_wb, e_alu);
        check("write_reg_wb", write_reg_wb, e_wr);
        check("mem_fault", mem_fault, e_fault);
        if (dmem_req)  cnt_req++;
        if (mem_stall) cnt_stall++;
        if (mem_fault) cnt_fault++;
        n_fault = !reset && ((m_op && !m_al) || x_to);
        if (reset || x_stall || n_fault) begin
            n_rw = 0; n_mtr = 0; n_rd = 0; n_alu = 0; n_wr = 0;
        end else begin
            n_rw  = reg_write_mem;
            n_mtr = mem_to_reg_mem;
            n_alu = alu_result_mem;
            n_wr  = write_reg_mem;
            n_rd  = (x_req && dmem_ack && mem_read_mem && !mem_write_mem) ? dmem_rdata : 32'd0;
        end
        @(posedge clk);
        e_rw = n_rw; e_mtr = n_mtr; e_rd = n_rd; e_alu = n_alu; e_wr = n_wr; e_fault = n_fault;
        age = (reset || !x_stall) ? 0 : age + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_nop();
        reg_write_mem = 0; mem_to_reg_mem = 0; mem_read_mem = 0; mem_write_mem = 0;
        branch_mem = 0; zero_mem = 0; alu_result_mem = 0; read_data2_mem = 0;
        write_reg_mem = 0; dmem_ack = 0; dmem_rdata = $urandom;
    endtask

    task automatic clear_counts();
        cnt_req = 0; cnt_stall = 0; cnt_fault = 0;
    endtask

    // Present one EX/MEM instruction, hold it for as long as the stage is
    // expected to stall, then put a NOP behind it. ack_at < 0 means no ack.
    task automatic issue(input logic rw, input logic mtr, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] wreg, input logic [31:0] rdata_v, input int ack_at);
        int hold;
        if (!(rd | wr) || addr[1:0] != 2'b00) hold = 1;
        else if (ack_at >= 0 && ack_at < TIMEOUT) hold = ack_at + 1;
        else hold = TIMEOUT;
        for (int k = 0; k < hold; k++) begin
            reg_write_mem = rw; mem_to_reg_mem = mtr; mem_read_mem = rd; mem_write_mem = wr;
            alu_result_mem = addr; read_data2_mem = wdata; write_reg_mem = wreg;
            dmem_ack   = (k == ack_at);
            dmem_rdata = (k == ack_at) ? rdata_v : $urandom;
            @(posedge clk); #1;
        end
        drive_nop();
    endtask

    task automatic wb_sample();
        @(negedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        drive_nop();
        clear_counts();
        @(posedge clk); @(posedge clk);
        @(negedge clk); #1;
        check("reset reg_write_wb", reg_write_wb, 0);
        check("reset read_data_wb", read_data_wb, 0);
        check("reset alu_result_wb", alu_result_wb, 0);
        check("reset mem_fault", mem_fault, 0);
        check("reset dmem_req", dmem_req, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADD: non-memory, one-cycle latency
        clear_counts();
        issue(1, 0, 0, 0, 32'h1234, 32'h0, 5'd5, 32'h0, -1);
        wb_sample();
        check("add alu_result_wb", alu_result_wb, 32'h1234);
        check("add write_reg_wb", write_reg_wb, 5);
        check("add reg_write_wb", reg_write_wb, 1);
        check("add stall cycles", cnt_stall, 0);
        @(posedge clk); #1;

        // zero-wait LW
        clear_counts();
        issue(1, 1, 1, 0, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 0);
        check("lw0 stall cycles", cnt_stall, 0);
        wb_sample();
        check("lw0 read_data_wb", read_data_wb, 32'hDEADBEEF);
        check("lw0 mem_to_reg_wb", mem_to_reg_wb, 1);
        check("lw0 write_reg_wb", write_reg_wb, 7);
        @(posedge clk); #1;

        // SW acked after 3 cycles (ack lands in the last allowed cycle)
        clear_counts();
        issue(0, 0, 0, 1, 32'h20, 32'hA5A5A5A5, 5'd0, 32'h0, 3);
        check("sw3 stall cycles", cnt_stall, 3);
        check("sw3 req cycles", cnt_req, 4);
        wb_sample();
        check("sw3 reg_write_wb", reg_write_wb, 0);
        check("sw3 alu_result_wb", alu_result_wb, 32'h20);
        check("sw3 mem_fault", mem_fault, 0);
        @(posedge clk); #1;

        // LW acked after 1 cycle
        clear_counts();
        issue(1, 1, 1, 0, 32'h44, 32'h0, 5'd9, 32'h0BADF00D, 1);
        check("lw1 stall cycles", cnt_stall, 1);
        wb_sample();
        check("lw1 read_data_wb", read_data_wb, 32'h0BADF00D);
        @(posedge clk); #1;

        // read+write both set: write wins, no read data captured
        clear_counts();
        issue(1, 1, 1, 1, 32'h88, 32'h11112222, 5'd3, 32'h77777777, 1);
        wb_sample();
        check("rw read_data_wb", read_data_wb, 0);
        check("rw reg_write_wb", reg_write_wb, 1);
        @(posedge clk); #1;

        // timeout: LW never acked
        clear_counts();
        issue(1, 1, 1, 0, 32'h200, 32'h0, 5'd4, 32'h0, -1);
        check("to req cycles", cnt_req, 4);
        check("to stall cycles", cnt_stall, 3);
        wb_sample();
        check("to mem_fault", mem_fault, 1);
        check("to reg_write_wb", reg_write_wb, 0);
        check("to dmem_req after", dmem_req, 0);
        @(posedge clk); #1;
        check("to fault count", cnt_fault, 1);

        // misaligned LW
        clear_counts();
        issue(1, 1, 1, 0, 32'h102, 32'h0, 5'd6, 32'h0, 0);
        check("mis req cycles", cnt_req, 0);
        check("mis stall cycles", cnt_stall, 0);
        wb_sample();
        check("mis mem_fault", mem_fault, 1);
        check("mis reg_write_wb", reg_write_wb, 0);
        @(posedge clk); #1;

        // reset asserted in WAIT cycle 2
        clear_counts();
        reg_write_mem = 1; mem_to_reg_mem = 1; mem_read_mem = 1;
        alu_result_mem = 32'h40; write_reg_mem = 5'd2; dmem_ack = 0;
        @(posedge clk); #1;
        check("rst wait entered", state_dbg, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rst dmem_req", dmem_req, 0);
        check("rst mem_stall", mem_stall, 0);
        check("rst reg_write_wb", reg_write_wb, 0);
        check("rst write_reg_wb", write_reg_wb, 0);
        check("rst mem_fault", mem_fault, 0);
        check("rst state", state_dbg, 0);
        drive_nop();
        @(posedge clk); #1;
        reset = 1'b0;
        wb_sample();
        check("rst fault count", cnt_fault, 0);
        @(posedge clk); #1;

        // branch resolution
        branch_mem = 1; zero_mem = 1; #1;
        check("branch taken", pc_src, 1);
        zero_mem = 0; #1;
        check("branch not taken", pc_src, 0);
        @(posedge clk); #1;
        drive_nop();
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the sequence above is a few hundred cycles at most.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
